cd_digit_scan_mux: RTL and testbench

Multiplexed display scanner that sits directly upstream of the BCD-to-7-segment decoder. It holds N_DIGITS packed BCD digits and time-slices them onto a single 4-bit D,C,B,A bus. In step with each slice it drives one-hot digit anode enables, so one shared decoder serves a multi-digit common-anode display. Captured values are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/cd_digit_scan_mux_if.sv | 25 ++
 rtl/cd_digit_scan_mux.sv | 118 +++++++++++
 tb/tb_cd_digit_scan_mux.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cd_digit_scan_mux_if.sv
// rtl/cd_digit_scan_mux_if.sv - digit scan mux capture inputs and decoder/anode outputs
interface cd_digit_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*N_DIGITS-1:0] digits_in;
    logic                  D;
    logic                  C;
    logic                  B;
    logic                  A;
    logic [N_DIGITS-1:0]   an;
    logic                  blank;
    logic                  frame_done;

    modport master (
        output en, load, digits_in,
        input  D, C, B, A, an, blank, frame_done
    );

    modport slave (
        input  en, load, digits_in,
        output D, C, B, A, an, blank, frame_done
    );
endinterface

// File: rtl/cd_digit_scan_mux.sv
// rtl/cd_digit_scan_mux.sv - frame-buffered BCD digit scanner feeding one shared 7-seg decoder
// Optional macro CD_SCAN_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module cd_digit_scan_mux #(
    parameter int N_DIGITS         = 4,
    parameter int PRESCALE         = 50000,
    parameter int GUARD            = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cd_digit_scan_mux_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;

    localparam logic [PW-1:0]       PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]       GUARD_L = PW'(GUARD);
    localparam logic [IW-1:0]       IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [DW-1:0]       r_pend;
    logic                r_pend_valid;
    logic [DW-1:0]       r_active;
    logic [3:0]          r_dcba;
    logic [N_DIGITS-1:0] r_an;
    logic                r_blank;
    logic                r_frame_done;

    logic                w_pre_last;
    logic                w_wrap;
    logic [PW-1:0]       w_pre_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [DW-1:0]       w_active_nxt;
    logic [3:0]          w_digit;
    logic                w_guard;
    logic                w_suppress;
    logic [N_DIGITS-1:0] w_onehot;

    assign w_pre_last = (r_pre == PRE_MAX);
    assign w_wrap     = bus.en && w_pre_last && (r_idx == IDX_MAX);
    assign w_pre_nxt  = !bus.en ? r_pre : (w_pre_last ? '0 : r_pre + 1'b1);
    assign w_idx_nxt  = (bus.en && w_pre_last) ? ((r_idx == IDX_MAX) ? '0 : r_idx + 1'b1) : r_idx;

    // A load coinciding with the wrap bypasses pending so the new value shows this frame.
    assign w_active_nxt = !w_wrap      ? r_active     :
                          bus.load     ? bus.digits_in :
                          r_pend_valid ? r_pend        : r_active;

    assign w_digit  = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
    assign w_guard  = (w_pre_nxt < GUARD_L);
    assign w_onehot = N_DIGITS'(1) << w_idx_nxt;

`ifdef CD_SCAN_LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] w_lz;

    // w_lz[i] is set when digit i and every more-significant digit are zero.
    always_comb begin
        w_lz = '0;
        w_lz[N_DIGITS-1] = (w_active_nxt[DW-1 -: 4] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            w_lz[i] = (w_active_nxt[4*i +: 4] == 4'd0) && w_lz[i+1];
        end
    end

    assign w_suppress = (w_idx_nxt != '0) && w_lz[w_idx_nxt];
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_active     <= '0;
            r_dcba       <= 4'd0;
            r_an         <= AN_OFF;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_active     <= w_active_nxt;
                r_pend_valid <= 1'b0;
            end else if (bus.load) begin
                r_pend       <= bus.digits_in;
                r_pend_valid <= 1'b1;
            end
            r_pre        <= w_pre_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_done <= w_wrap;
            if (bus.en) begin
                r_dcba <= w_digit;
                if (w_guard || w_suppress) begin
                    r_an    <= AN_OFF;
                    r_blank <= 1'b1;
                end else begin
                    r_an    <= (ANODE_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
                    r_blank <= 1'b0;
                end
            end else begin
                r_an    <= AN_OFF;
                r_blank <= 1'b1;
            end
        end
    end

    assign bus.D          = r_dcba[3];
    assign bus.C          = r_dcba[2];
    assign bus.B          = r_dcba[1];
    assign bus.A          = r_dcba[0];
    assign bus.an         = r_an;
    assign bus.blank      = r_blank;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_cd_digit_scan_mux.sv
// tb/tb_cd_digit_scan_mux.sv - scoreboard bench for cd_digit_scan_mux (4 digits, prescale 4, guard 1)
module tb_cd_digit_scan_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cd_digit_scan_mux_if #(.N_DIGITS(4)) bus ();

    cd_digit_scan_mux #(
        .N_DIGITS(4), .PRESCALE(4), .GUARD(1), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] dcba;
        logic [3:0] an;
        logic       blank;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    obs_t s;
    int   errors = 0;
    int   checks = 0;

    logic [1:0]  m_pre, m_idx;
    logic [15:0] m_pend, m_act;
    logic        m_pv;
    obs_t        m_out;

    task automatic model_step(input logic rstn, input logic en, input logic ld, input logic [15:0] din);
        logic wrap;
        logic lz_hit;
        if (!rstn) begin
            m_pre = 0; m_idx = 0; m_pend = 0; m_pv = 0; m_act = 0;
            m_out.dcba = 4'h0; m_out.an = 4'hF; m_out.blank = 1'b1; m_out.fd = 1'b0;
        end else if (!en) begin
            if (ld) begin m_pend = din; m_pv = 1'b1; end
            m_out.an = 4'hF; m_out.blank = 1'b1; m_out.fd = 1'b0;
        end else begin
            wrap = (m_pre == 2'd3) && (m_idx == 2'd3);
            if (m_pre == 2'd3) begin m_pre = 2'd0; m_idx = m_idx + 2'd1; end
            else m_pre = m_pre + 2'd1;
            if (wrap) begin
                if (ld) m_act = din;
                else if (m_pv) m_act = m_pend;
                m_pv = 1'b0;
            end else if (ld) begin
                m_pend = din; m_pv = 1'b1;
            end
            m_out.fd   = wrap;
            m_out.dcba = m_act[{m_idx, 2'b00} +: 4];
            lz_hit = 1'b0;
`ifdef CD_SCAN_LEADING_ZERO_BLANK_EN
            lz_hit = (m_idx != 2'd0) && ((m_act >> (4 * m_idx)) == 16'h0);
`endif
            if (m_pre == 2'd0 || lz_hit) begin
                m_out.an = 4'hF; m_out.blank = 1'b1;
            end else begin
                m_out.an = ~(4'b0001 << m_idx); m_out.blank = 1'b0;
            end
        end
        exp_q.push_back(m_out);
    endtask

    task automatic step(input logic rstn, input logic en, input logic ld, input logic [15:0] din);
        obs_t e;
        rst_n = rstn; bus.en = en; bus.load = ld; bus.digits_in = din;
        model_step(rstn, en, ld, din);
        @(posedge clk); #1;
        s = {bus.D, bus.C, bus.B, bus.A, bus.an, bus.blank, bus.frame_done};
        e = exp_q.pop_front();
        checks++;
        if (s !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got dcba/an/blank/fd=%h/%h/%b/%b exp=%h/%h/%b/%b",
                     $time, s.dcba, s.an, s.blank, s.fd, e.dcba, e.an, e.blank, e.fd);
        end
    endtask

    task automatic wait_wrap();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            found = (s.fd === 1'b1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_wrap no frame_done within 40 cycles");
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h9999);
        checks++;
        if (s.an !== 4'hF || s.dcba !== 4'h0 || s.blank !== 1'b1 || s.fd !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got an=%h dcba=%h blank=%b fd=%b exp an=f dcba=0 blank=1 fd=0",
                     s.an, s.dcba, s.blank, s.fd);
        end
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (s.dcba !== 4'h0) bad++;
        end
        checks++;
        if (bad != 0 || s.fd !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_zero nonzero=%0d fd_at_16=%b exp nonzero=0 fd=1", bad, s.fd);
        end
    endtask

    task automatic test_load_display();
        logic [15:0] v;
        logic [3:0]  exp_an, exp_d;
        int slot;
        v = 16'h1234;
        step(1'b1, 1'b1, 1'b1, v);
        wait_wrap();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step(1'b1, 1'b1, 1'b0, 16'h0);
            slot   = k / 4;
            exp_an = (k % 4 == 0) ? 4'hF : ~(4'b0001 << slot);
            exp_d  = v[4*slot +: 4];
            checks++;
            if (s.an !== exp_an || s.dcba !== exp_d || s.blank !== (k % 4 == 0) || s.fd !== (k == 0)) begin
                errors++;
                $display("FAIL display_1234 k=%0d got an=%h dcba=%h blank=%b fd=%b exp an=%h dcba=%h",
                         k, s.an, s.dcba, s.blank, s.fd, exp_an, exp_d);
            end
        end
        step(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (s.fd !== 1'b1) begin
            errors++;
            $display("FAIL frame_period fd=%b exp 1 after 16 cycles", s.fd);
        end
    endtask

    task automatic test_last_load_wins();
        logic [15:0] v;
        v = 16'hABCD;
        for (int k = 1; k < 32; k++) begin
            if (k == 5)      step(1'b1, 1'b1, 1'b1, 16'h5678);
            else if (k == 9) step(1'b1, 1'b1, 1'b1, 16'hABCD);
            else             step(1'b1, 1'b1, 1'b0, 16'h0);
            if (k >= 12 && k < 16) begin
                checks++;
                if (s.dcba !== 4'h1) begin
                    errors++;
                    $display("FAIL frame_not_torn k=%0d got dcba=%h exp 1", k, s.dcba);
                end
            end else if (k >= 16) begin
                checks++;
                if (s.dcba !== v[4*((k-16)/4) +: 4] || s.fd !== (k == 16)) begin
                    errors++;
                    $display("FAIL last_load_wins k=%0d got dcba=%h fd=%b exp dcba=%h",
                             k, s.dcba, s.fd, v[4*((k-16)/4) +: 4]);
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        int bad = 0;
        wait_wrap();
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (s.an !== 4'hF || s.blank !== 1'b1 || s.fd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_off_dark bad_cycles=%0d exp 0", bad);
        end
        step(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (s.an !== 4'b1011 || s.dcba !== 4'hB || s.blank !== 1'b0) begin
            errors++;
            $display("FAIL en_resume got an=%h dcba=%h exp an=b dcba=b", s.an, s.dcba);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (s.fd !== 1'b1) begin
            errors++;
            $display("FAIL en_resume_wrap fd=%b exp 1", s.fd);
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2];
        logic [3:0]  exp_an;
        logic        supp;
        int slot;
        vals[0] = 16'h0042;
        vals[1] = 16'h0000;
        for (int t = 0; t < 2; t++) begin
            step(1'b1, 1'b1, 1'b1, vals[t]);
            wait_wrap();
            for (int k = 0; k < 16; k++) begin
                if (k > 0) step(1'b1, 1'b1, 1'b0, 16'h0);
                slot = k / 4;
                supp = 1'b0;
`ifdef CD_SCAN_LEADING_ZERO_BLANK_EN
                supp = (t == 0) ? (slot >= 2) : (slot >= 1);
`endif
                exp_an = (k % 4 == 0 || supp) ? 4'hF : ~(4'b0001 << slot);
                checks++;
                if (s.an !== exp_an || s.blank !== (exp_an == 4'hF) || s.dcba !== vals[t][4*slot +: 4]) begin
                    errors++;
                    $display("FAIL leading_zero val=%h k=%0d got an=%h blank=%b dcba=%h exp an=%h",
                             vals[t], k, s.an, s.blank, s.dcba, exp_an);
                end
            end
        end
    endtask

    task automatic test_wrap_load();
        wait_wrap();
        for (int k = 1; k < 16; k++) begin
            if (k == 3) step(1'b1, 1'b1, 1'b1, 16'h1111);
            else        step(1'b1, 1'b1, 1'b0, 16'h0);
        end
        step(1'b1, 1'b1, 1'b1, 16'h0007);
        checks++;
        if (s.fd !== 1'b1 || s.dcba !== 4'h7) begin
            errors++;
            $display("FAIL wrap_load got fd=%b dcba=%h exp fd=1 dcba=7", s.fd, s.dcba);
        end
        for (int k = 17; k <= 33; k++) step(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (s.an !== 4'b1110 || s.dcba !== 4'h7) begin
            errors++;
            $display("FAIL wrap_load_pending_cleared got an=%h dcba=%h exp an=e dcba=7", s.an, s.dcba);
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        wait_wrap();
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h9999);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (s.dcba !== 4'h0) bad++;
            if (k == 16 && s.fd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_midframe bad=%0d exp 0 (pending discarded, restart at digit 0)", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.digits_in = '0;
        test_reset();
        test_load_display();
        test_last_load_wins();
        test_enable_freeze();
        test_leading_zero();
        test_wrap_load();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
